// File: rtl/axi_lite_regbank_slave_if.sv
// rtl/axi_lite_regbank_slave_if.sv - AXI4-Lite bus bundle (32-bit data, no PROT) with master/slave views
interface axi_lite_regbank_slave_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regbank_slave.sv
// rtl/axi_lite_regbank_slave.sv - AXI4-Lite slave: 15 R/W registers plus read-only
// write/read transaction counter word at index 15; SLVERR on illegal accesses.
module axi_lite_regbank_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  axi_lite_regbank_slave_if.slave   s_axi
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] STATUS_IDX  = 4'd15;

  logic [31:0] regs [0:14];
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  logic [0:0]  w_state;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic [0:0]  r_state;
  logic        arready_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [3:0]  aw_idx;
  logic [3:0]  ar_idx;
  logic        aw_legal;
  logic        ar_legal;
  logic        wr_ok;

  // Only the low 64 bytes decode; the byte offset within a word is ignored.
  assign aw_addr  = s_axi.awaddr;
  assign ar_addr  = s_axi.araddr;
  assign aw_idx   = aw_addr[5:2];
  assign ar_idx   = ar_addr[5:2];
  assign aw_legal = (aw_addr >> 6) == '0;
  assign ar_legal = (ar_addr >> 6) == '0;
  assign wr_ok    = aw_legal && (aw_idx != STATUS_IDX);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_cnt    <= '0;
      for (int i = 0; i < 15; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            if (wr_ok) begin
              for (int b = 0; b < 4; b++) begin
                if (s_axi.wstrb[b]) begin
                  regs[aw_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
              end
              if (wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
              end
              bresp_q <= RESP_OKAY;
            end else begin
              bresp_q <= RESP_SLVERR;
            end
            bvalid_q <= 1'b1;
            w_state  <= W_RESP;
          end else if (s_axi.awvalid && s_axi.wvalid) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Reads sample regs/counters before this edge's write, so same-edge reads see old values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rd_cnt    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arready_q) begin
            arready_q <= 1'b0;
            if (ar_legal) begin
              rdata_q <= (ar_idx == STATUS_IDX) ? {rd_cnt, wr_cnt} : regs[ar_idx];
              rresp_q <= RESP_OKAY;
              if (rd_cnt != 16'hFFFF) begin
                rd_cnt <= rd_cnt + 16'd1;
              end
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end
            rvalid_q <= 1'b1;
            r_state  <= R_DATA;
          end else if (s_axi.arvalid) begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

endmodule
